// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the 32-bit-over-16-bit SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_WAIT_CYCLES = 3;
  localparam logic [31:0] DEF_DATA_BASE   = 32'd1024;

  // Word index relative to the SRAM window; upper bits wrap away.
  function automatic logic [16:0] word_index(input logic [31:0] addr, input logic [31:0] base);
    return 17'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Wait-state counter: counts enabled cycles, flags the last one of each half-access.
module sram_wait_cnt
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [3:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 4'd0;
    end else if (clear) begin
      r_count <= 4'd0;
    end else if (enable) begin
      r_count <= r_count + 4'd1;
    end
  end

  assign tc = enable && (r_count == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_ctrl.sv
// Splits each 32-bit MEM-stage load/store into two timed 16-bit SRAM accesses.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter logic [31:0] DATA_BASE   = DEF_DATA_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_op_wr;
  logic [16:0] r_index;
  logic [31:0] r_wdata;
  logic        w_req;
  logic        w_busy;
  logic        w_tc;
  logic [16:0] w_index;

  assign w_req   = wr_en | rd_en;
  assign w_busy  = (r_state == ST_LOW) || (r_state == ST_HIGH);
  assign w_index = word_index(address, DATA_BASE);

  sram_wait_cnt #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (~w_busy | w_tc),
    .enable (w_busy),
    .tc     (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    ready        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready = ~w_req;
        if (w_req) w_state_next = ST_LOW;
      end
      ST_LOW:  if (w_tc) w_state_next = ST_HIGH;
      ST_HIGH: if (w_tc) w_state_next = ST_DONE;
      ST_DONE: begin
        ready        = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // SRAM pins are loaded one edge ahead so they are stable for the whole half-access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_wr     <= 1'b0;
      r_index     <= 17'd0;
      r_wdata     <= 32'd0;
      read_data   <= 32'd0;
      sram_addr   <= 18'd0;
      sram_dq_out <= 16'd0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_op_wr     <= wr_en;
            r_index     <= w_index;
            r_wdata     <= write_data;
            sram_addr   <= {w_index, 1'b0};
            sram_dq_out <= write_data[15:0];
            sram_dq_oe  <= wr_en;
            sram_we_n   <= ~wr_en;
          end
        end
        ST_LOW: begin
          if (w_tc) begin
            if (!r_op_wr) read_data[15:0] <= sram_dq_in;
            sram_addr   <= {r_index, 1'b1};
            sram_dq_out <= r_wdata[31:16];
          end
        end
        ST_HIGH: begin
          if (w_tc) begin
            if (!r_op_wr) read_data[31:16] <= sram_dq_in;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
